// File: rtl/coherence_bus_arbiter.sv
// Coherence bus arbiter: captures per-core miss/invalidate requests, picks one owner
// round-robin, snoops the other caches, and sequences the fill from a peer cache or dmem.
module coherence_bus_arbiter #(
    parameter int unsigned NUM_CORES = 2,
    parameter int unsigned ADDR_W    = 13
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CORES-1:0]          read_miss_i,
    input  logic [NUM_CORES-1:0]          write_miss_i,
    input  logic [NUM_CORES-1:0]          invalidate_i,
    input  logic [NUM_CORES*ADDR_W-1:0]   bico_i,
    input  logic [NUM_CORES-1:0]          cpu_search_found_i,
    input  logic                          mem_rdy_i,
    output logic [NUM_CORES-1:0]          grant_o,
    output logic [ADDR_W-1:0]             boci_o,
    output logic [NUM_CORES-1:0]          cpu_search_o,
    output logic [NUM_CORES-1:0]          invalidate_from_other_cpu_o,
    output logic [2*NUM_CORES-1:0]        cpu_datasel_o,
    output logic                          mem_re_o,
    output logic                          busy_o
);

    localparam int unsigned OwW = $clog2(NUM_CORES);

    typedef enum logic [1:0] {OpRmiss, OpWmiss, OpInv} op_e;
    typedef enum logic [2:0] {StIdle, StSnoop, StXfer, StMem, StDone} state_e;

    state_e                              state_q, state_d;
    logic   [OwW-1:0]                    owner_q, owner_d;
    logic   [OwW-1:0]                    rr_q, rr_d;
    op_e                                 cur_op_q, cur_op_d;
    logic   [ADDR_W-1:0]                 boci_q, boci_d;
    logic   [NUM_CORES-1:0]              pend_q, pend_d;
    logic   [NUM_CORES-1:0][1:0]         op_q, op_d;
    logic   [NUM_CORES-1:0][ADDR_W-1:0]  addr_q, addr_d;

    logic                   pick_valid;
    logic [OwW-1:0]         pick_idx;
    int unsigned            scan_idx;
    logic [NUM_CORES-1:0]   owner_oh;
    logic                   found;
    logic                   clr_valid;
    logic [NUM_CORES-1:0]   req_any;

    assign owner_oh = {{(NUM_CORES-1){1'b0}}, 1'b1} << owner_q;
    assign found    = |(cpu_search_found_i & ~owner_oh);
    assign req_any  = read_miss_i | write_miss_i | invalidate_i;
    assign boci_o   = boci_q;
    assign busy_o   = (state_q != StIdle);

    // Round-robin scan of pending requests starting at rr_q.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan_idx   = 0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            scan_idx = (32'(rr_q) + k) % NUM_CORES;
            if (!pick_valid && pend_q[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = OwW'(scan_idx);
            end
        end
    end

    // Transaction FSM: next state, owner bookkeeping and all bus strobes.
    always_comb begin
        state_d                     = state_q;
        owner_d                     = owner_q;
        cur_op_d                    = cur_op_q;
        boci_d                      = boci_q;
        rr_d                        = rr_q;
        clr_valid                   = 1'b0;
        grant_o                     = '0;
        cpu_search_o                = '0;
        invalidate_from_other_cpu_o = '0;
        cpu_datasel_o               = '0;
        mem_re_o                    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    owner_d  = pick_idx;
                    cur_op_d = op_e'(op_q[pick_idx]);
                    boci_d   = addr_q[pick_idx];
                    state_d  = StSnoop;
                end
            end
            StSnoop: begin
                cpu_search_o = ~owner_oh;
                if (cur_op_q != OpRmiss) begin
                    invalidate_from_other_cpu_o = ~owner_oh;
                    state_d                     = StDone;
                end else begin
                    state_d = found ? StXfer : StMem;
                end
            end
            StXfer: begin
                // Keep the search asserted so the supplying cache drives its line.
                grant_o                          = owner_oh;
                cpu_search_o                     = ~owner_oh;
                cpu_datasel_o[2*owner_q +: 2]    = 2'b01;
                state_d                          = StDone;
            end
            StMem: begin
                grant_o  = owner_oh;
                mem_re_o = 1'b1;
                if (mem_rdy_i) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (cur_op_q != OpRmiss) begin
                    grant_o = owner_oh;
                end
                clr_valid = 1'b1;
                rr_d      = (owner_q == OwW'(NUM_CORES-1)) ? '0 : owner_q + 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Request capture; a new pulse in the same cycle as the owner's clear is kept.
    always_comb begin
        pend_d = pend_q;
        op_d   = op_q;
        addr_d = addr_q;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (clr_valid && (owner_q == OwW'(i))) begin
                pend_d[i] = 1'b0;
            end
            if ((!pend_q[i] || (clr_valid && (owner_q == OwW'(i)))) && req_any[i]) begin
                pend_d[i] = 1'b1;
                op_d[i]   = invalidate_i[i] ? OpInv : (write_miss_i[i] ? OpWmiss : OpRmiss);
                addr_d[i] = bico_i[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // State and request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            rr_q     <= '0;
            cur_op_q <= OpRmiss;
            boci_q   <= '0;
            pend_q   <= '0;
            op_q     <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            cur_op_q <= cur_op_d;
            boci_q   <= boci_d;
            pend_q   <= pend_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
        end
    end

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Bench for coherence_bus_arbiter: directed scenarios then random traffic, every cycle
// compared against a transaction-level reference model.
module tb_coherence_bus_arbiter;

    localparam int N  = 2;
    localparam int AW = 13;
    localparam int BW = N * AW;

    // Reference-model transaction steps and request kinds.
    localparam int PhIdle = 0, PhSnoop = 1, PhXfer = 2, PhMem = 3, PhDone = 4;
    localparam int OpR = 0, OpW = 1, OpI = 2;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    read_miss, write_miss, invalidate, found_in;
    logic [BW-1:0]   bico;
    logic            mem_rdy;
    logic [N-1:0]    grant, cpu_search, inv_other;
    logic [AW-1:0]   boci;
    logic [2*N-1:0]  datasel;
    logic            mem_re, busy;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int            m_phase, m_owner, m_op, m_rr;
    int            m_pend [N];
    int            m_opq  [N];
    logic [AW-1:0] m_addr [N];
    logic [AW-1:0] m_boci;

    coherence_bus_arbiter #(.NUM_CORES(N), .ADDR_W(AW)) dut (
        .clk                         (clk),
        .rst_n                       (rst_n),
        .read_miss_i                 (read_miss),
        .write_miss_i                (write_miss),
        .invalidate_i                (invalidate),
        .bico_i                      (bico),
        .cpu_search_found_i          (found_in),
        .mem_rdy_i                   (mem_rdy),
        .grant_o                     (grant),
        .boci_o                      (boci),
        .cpu_search_o                (cpu_search),
        .invalidate_from_other_cpu_o (inv_other),
        .cpu_datasel_o               (datasel),
        .mem_re_o                    (mem_re),
        .busy_o                      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] bsl(input int core, input logic [AW-1:0] a);
        logic [BW-1:0] v;
        v = '0;
        v[core*AW +: AW] = a;
        return v;
    endfunction

    task automatic m_reset();
        m_phase = PhIdle;
        m_owner = 0;
        m_op    = OpR;
        m_rr    = 0;
        m_boci  = '0;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0;
            m_opq[i]  = OpR;
            m_addr[i] = '0;
        end
    endtask

    // Compare every DUT output against what the model says for the current step.
    task automatic check_outputs();
        logic [N-1:0]   oh, e_grant, e_search, e_inv;
        logic [2*N-1:0] e_ds;
        oh = '0;
        oh[m_owner] = 1'b1;
        e_grant  = ((m_phase == PhXfer) || (m_phase == PhMem) ||
                    (m_phase == PhDone && m_op != OpR)) ? oh : '0;
        e_search = ((m_phase == PhSnoop) || (m_phase == PhXfer)) ? ~oh : '0;
        e_inv    = (m_phase == PhSnoop && m_op != OpR) ? ~oh : '0;
        e_ds     = '0;
        if (m_phase == PhXfer) e_ds[2*m_owner +: 2] = 2'b01;
        check("grant", grant, e_grant);
        check("cpu_search", cpu_search, e_search);
        check("invalidate_other", inv_other, e_inv);
        check("cpu_datasel", datasel, e_ds);
        check("mem_re", mem_re, (m_phase == PhMem) ? 1 : 0);
        check("busy", busy, (m_phase != PhIdle) ? 1 : 0);
        check("boci", boci, m_boci);
    endtask

    // Advance the model across one clock edge given the inputs seen at that edge.
    task automatic m_edge(input logic [N-1:0] rm, input logic [N-1:0] wm,
                          input logic [N-1:0] iv, input logic [BW-1:0] b,
                          input logic [N-1:0] fnd, input logic mr);
        int clr;
        int sel;
        clr = -1;
        case (m_phase)
            PhIdle: begin
                sel = -1;
                for (int k = 0; k < N; k++) begin
                    if (sel < 0 && m_pend[(m_rr + k) % N] != 0) sel = (m_rr + k) % N;
                end
                if (sel >= 0) begin
                    m_owner = sel;
                    m_op    = m_opq[sel];
                    m_boci  = m_addr[sel];
                    m_phase = PhSnoop;
                end
            end
            PhSnoop: begin
                if (m_op == OpR) begin
                    logic [N-1:0] others;
                    others = fnd;
                    others[m_owner] = 1'b0;
                    m_phase = (others != 0) ? PhXfer : PhMem;
                end else begin
                    m_phase = PhDone;
                end
            end
            PhXfer: m_phase = PhDone;
            PhMem:  if (mr) m_phase = PhDone;
            default: begin
                clr     = m_owner;
                m_rr    = (m_owner + 1) % N;
                m_phase = PhIdle;
            end
        endcase
        for (int i = 0; i < N; i++) begin
            int was;
            was = m_pend[i];
            if (clr == i) m_pend[i] = 0;
            if ((was == 0 || clr == i) && (rm[i] | wm[i] | iv[i])) begin
                m_pend[i] = 1;
                m_opq[i]  = iv[i] ? OpI : (wm[i] ? OpW : OpR);
                m_addr[i] = b[i*AW +: AW];
            end
        end
    endtask

    // One clock: drive inputs, check outputs, cross the edge, return at the next negedge.
    task automatic step(input logic [N-1:0] rm, input logic [N-1:0] wm,
                        input logic [N-1:0] iv, input logic [BW-1:0] b,
                        input logic [N-1:0] fnd, input logic mr);
        read_miss  = rm;
        write_miss = wm;
        invalidate = iv;
        bico       = b;
        found_in   = fnd;
        mem_rdy    = mr;
        #1;
        check_outputs();
        @(posedge clk);
        m_edge(rm, wm, iv, b, fnd, mr);
        @(negedge clk);
    endtask

    task automatic idle_step();
        step('0, '0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        read_miss = '0; write_miss = '0; invalidate = '0;
        bico = '0; found_in = '0; mem_rdy = 1'b0;
        m_reset();
        #12;
        // Reset state
        check("rst_grant", grant, 0);
        check("rst_mem_re", mem_re, 0);
        check("rst_busy", busy, 0);
        check("rst_boci", boci, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_step();

        // Core0 read miss, dmem fill, mem_rdy four cycles after mem_re
        step(2'b01, '0, '0, bsl(0, 13'h0104), '0, 1'b0);
        idle_step();
        check("t2_search", cpu_search, 2'b10);
        check("t2_boci", boci, 13'h0104);
        step('0, '0, '0, '0, 2'b00, 1'b0);
        check("t2_grant", grant, 2'b01);
        check("t2_mem_re", mem_re, 1);
        check("t2_datasel", datasel, 4'b0000);
        for (int c = 0; c < 4; c++) step('0, '0, '0, '0, '0, 1'b0);
        step('0, '0, '0, '0, '0, 1'b1);
        check("t2_done_grant", grant, 2'b00);
        check("t2_done_mem_re", mem_re, 0);
        idle_step();
        idle_step();

        // Core1 read miss served by core0's cache
        step(2'b10, '0, '0, bsl(1, 13'h00AA), '0, 1'b0);
        idle_step();
        step('0, '0, '0, '0, 2'b01, 1'b0);
        check("t3_grant", grant, 2'b10);
        check("t3_datasel", datasel, 4'b0100);
        check("t3_mem_re", mem_re, 0);
        idle_step();
        idle_step();

        // Core0 invalidate
        step('0, '0, 2'b01, bsl(0, 13'h1FFC), '0, 1'b0);
        idle_step();
        check("t4_inv", inv_other, 2'b10);
        check("t4_search", cpu_search, 2'b10);
        check("t4_boci", boci, 13'h1FFC);
        step('0, '0, '0, '0, 2'b10, 1'b0);
        check("t4_grant", grant, 2'b01);
        idle_step();
        check("t4_grant_off", grant, 2'b00);
        idle_step();

        // Core1 write miss returns the pointer to core0
        step('0, 2'b10, '0, bsl(1, 13'h0777), '0, 1'b0);
        for (int c = 0; c < 4; c++) idle_step();

        // Simultaneous read misses; extra core0 pulse during its MEM wait is dropped
        step(2'b11, '0, '0, bsl(0, 13'h0010) | bsl(1, 13'h0020), '0, 1'b0);
        idle_step();
        check("t5_first_boci", boci, 13'h0010);
        step('0, '0, '0, '0, 2'b00, 1'b0);
        step(2'b01, '0, '0, bsl(0, 13'h0abc), '0, 1'b0);
        step('0, '0, '0, '0, '0, 1'b0);
        step('0, '0, '0, '0, '0, 1'b1);
        idle_step();
        idle_step();
        check("t5_second_boci", boci, 13'h0020);
        step('0, '0, '0, '0, 2'b00, 1'b0);
        step('0, '0, '0, '0, '0, 1'b1);
        idle_step();
        for (int c = 0; c < 3; c++) idle_step();
        check("t5_no_replay", busy, 0);
        step(2'b11, '0, '0, bsl(0, 13'h0101) | bsl(1, 13'h0202), '0, 1'b0);
        idle_step();
        check("t5_rr_core0", boci, 13'h0101);
        for (int c = 0; c < 8; c++) step('0, '0, '0, '0, 2'b01, 1'b0);

        // Reset during a MEM wait
        step(2'b01, '0, '0, bsl(0, 13'h0055), '0, 1'b0);
        idle_step();
        step('0, '0, '0, '0, 2'b00, 1'b0);
        step('0, '0, '0, '0, '0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        check("t6_grant", grant, 0);
        check("t6_mem_re", mem_re, 0);
        check("t6_busy", busy, 0);
        check("t6_boci", boci, 0);
        check("t6_search", cpu_search, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) idle_step();

        // Random traffic
        for (int c = 0; c < 500; c++) begin
            logic [N-1:0] rm, wm, iv;
            rm = N'($urandom) & N'($urandom) & N'($urandom);
            wm = N'($urandom) & N'($urandom) & N'($urandom) & N'($urandom);
            iv = N'($urandom) & N'($urandom) & N'($urandom) & N'($urandom);
            step(rm, wm, iv, BW'({$urandom, $urandom}), N'($urandom),
                 ($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
